// File: rtl/clock_time_counter_if.sv
// Bundle between the clock-time core and its key/seconds sources and display stage.
interface clock_time_counter_if;
  logic       sec_clk;
  logic       key_mode;
  logic       key_inc;
  logic [7:0] hour_bcd;
  logic [7:0] min_bcd;
  logic [7:0] sec_bcd;
  logic [1:0] mode;
  logic       day_pulse;

  // Stimulus side: seconds clock and key pulses out, time/mode in
  modport master (
    output sec_clk,
    output key_mode,
    output key_inc,
    input  hour_bcd,
    input  min_bcd,
    input  sec_bcd,
    input  mode,
    input  day_pulse
  );

  // Core side
  modport slave (
    input  sec_clk,
    input  key_mode,
    input  key_inc,
    output hour_bcd,
    output min_bcd,
    output sec_bcd,
    output mode,
    output day_pulse
  );
endinterface

// File: rtl/clock_time_counter.sv
// 24-hour BCD hh:mm:ss time-of-day counter with run / set-hour / set-minute modes.
module clock_time_counter #(
  parameter logic [7:0] INIT_HOUR = 8'h12,
  parameter logic [7:0] INIT_MIN  = 8'h00
) (
  input  logic                 clk_in,
  input  logic                 rst,
  clock_time_counter_if.slave  bus
);

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_SET_HOUR = 2'd1;
  localparam logic [1:0] ST_SET_MIN  = 2'd2;

  logic       s1, s2, s3;
  logic       tick;
  logic [1:0] state, state_n;
  logic [7:0] hour_q, min_q, sec_q;
  logic [7:0] hour_n, min_n, sec_n;
  logic       day_q, day_n;
  logic [8:0] s_inc, m_inc, h_inc;

  // BCD increment with wrap at {max_tens,max_ones}; returns {wrapped, next_value}
  function automatic logic [8:0] inc_bcd(input logic [7:0] v,
                                         input logic [3:0] max_tens,
                                         input logic [3:0] max_ones);
    logic [3:0] tens_p1;
    logic [3:0] ones_p1;
    tens_p1 = v[7:4] + 4'd1;
    ones_p1 = v[3:0] + 4'd1;
    if (v[7:4] == max_tens && v[3:0] == max_ones) return {1'b1, 8'h00};
    if (v[3:0] == 4'd9) return {1'b0, tens_p1, 4'd0};
    return {1'b0, v[7:4], ones_p1};
  endfunction

  // Seconds-clock synchronizer plus edge-detect delay stage
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= bus.sec_clk;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign tick = s2 & ~s3;

  // Mode state and registered time/day outputs
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state  <= ST_RUN;
      hour_q <= INIT_HOUR;
      min_q  <= INIT_MIN;
      sec_q  <= 8'h00;
      day_q  <= 1'b0;
    end else begin
      state  <= state_n;
      hour_q <= hour_n;
      min_q  <= min_n;
      sec_q  <= sec_n;
      day_q  <= day_n;
    end
  end

  // Next-state: counting in RUN, field edits in SET_*, mode advance wins over key_inc
  always_comb begin
    state_n = state;
    hour_n  = hour_q;
    min_n   = min_q;
    sec_n   = sec_q;
    day_n   = 1'b0;
    s_inc   = inc_bcd(sec_q, 4'd5, 4'd9);
    m_inc   = inc_bcd(min_q, 4'd5, 4'd9);
    h_inc   = inc_bcd(hour_q, 4'd2, 4'd3);
    case (state)
      ST_RUN: begin
        if (tick) begin
          sec_n = s_inc[7:0];
          if (s_inc[8]) begin
            min_n = m_inc[7:0];
            if (m_inc[8]) begin
              hour_n = h_inc[7:0];
              day_n  = h_inc[8];
            end
          end
        end
        if (bus.key_mode) state_n = ST_SET_HOUR;
      end
      ST_SET_HOUR: begin
        if (bus.key_mode)     state_n = ST_SET_MIN;
        else if (bus.key_inc) hour_n  = h_inc[7:0];
      end
      ST_SET_MIN: begin
        if (bus.key_mode) begin
          state_n = ST_RUN;
          sec_n   = 8'h00;
        end else if (bus.key_inc) begin
          min_n = m_inc[7:0];
        end
      end
      default: state_n = ST_RUN;
    endcase
  end

  assign bus.hour_bcd  = hour_q;
  assign bus.min_bcd   = min_q;
  assign bus.sec_bcd   = sec_q;
  assign bus.mode      = state;
  assign bus.day_pulse = day_q;

endmodule

// File: tb/tb_clock_time_counter.sv
// Bench for clock_time_counter: directed scenarios plus a randomized key/tick mix.
module tb_clock_time_counter;

  logic clk_in = 1'b0;
  logic rst;

  clock_time_counter_if bus_if ();

  clock_time_counter #(.INIT_HOUR(8'h12), .INIT_MIN(8'h00)) dut (
    .clk_in (clk_in),
    .rst    (rst),
    .bus    (bus_if)
  );

  always #5 clk_in = ~clk_in;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: seconds since midnight, mode number, rollover count
  int t_sod;
  int md;
  int days;

  // Observed day pulses (high cycles) and pulses seen at a non-midnight time
  int day_cnt = 0;
  int day_bad = 0;

  always @(negedge clk_in) begin
    if (bus_if.day_pulse) begin
      day_cnt++;
      if (bus_if.hour_bcd != 8'h00 || bus_if.min_bcd != 8'h00 || bus_if.sec_bcd != 8'h00)
        day_bad++;
    end
  end

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  task automatic model_reset();
    t_sod = 12 * 3600;
    md    = 0;
  endtask

  task automatic model_advance();
    t_sod = t_sod + 1;
    if (t_sod == 86400) begin
      t_sod = 0;
      days++;
    end
  endtask

  task automatic model_apply(input bit tk, input bit km, input bit ki);
    int h;
    int m;
    h = t_sod / 3600;
    m = (t_sod / 60) % 60;
    if (km) begin
      if (md == 0 && tk) model_advance();
      if (md == 2) t_sod = t_sod - (t_sod % 60);
      md = (md + 1) % 3;
    end else begin
      if (md == 0 && tk) model_advance();
      else if (md == 1 && ki) t_sod = ((h + 1) % 24) * 3600 + (t_sod % 3600);
      else if (md == 2 && ki) t_sod = t_sod - m * 60 + ((m + 1) % 60) * 60;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".hour"}, 32'(bus_if.hour_bcd), 32'(to_bcd(t_sod / 3600)));
    chk({tag, ".min"},  32'(bus_if.min_bcd),  32'(to_bcd((t_sod / 60) % 60)));
    chk({tag, ".sec"},  32'(bus_if.sec_bcd),  32'(to_bcd(t_sod % 60)));
    chk({tag, ".mode"}, 32'(bus_if.mode),     32'(md));
    chk({tag, ".days"}, 32'(day_cnt),         32'(days));
    chk({tag, ".dayok"}, 32'(day_bad),        32'd0);
  endtask

  // Key pulse(s) for one clk_in cycle; called and returns at a negedge
  task automatic key(input bit km, input bit ki);
    bus_if.key_mode = km;
    bus_if.key_inc  = ki;
    @(negedge clk_in);
    bus_if.key_mode = 1'b0;
    bus_if.key_inc  = 1'b0;
    model_apply(1'b0, km, ki);
  endtask

  // One seconds-clock pulse; optional keys land in the cycle the tick takes effect
  task automatic sec_tick(input bit km, input bit ki);
    bus_if.sec_clk = 1'b1;
    @(negedge clk_in);
    @(negedge clk_in);
    bus_if.key_mode = km;
    bus_if.key_inc  = ki;
    @(negedge clk_in);
    bus_if.key_mode = 1'b0;
    bus_if.key_inc  = 1'b0;
    model_apply(1'b1, km, ki);
    repeat (3) @(negedge clk_in);
    bus_if.sec_clk = 1'b0;
    repeat (3) @(negedge clk_in);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    repeat (2) @(negedge clk_in);
    rst = 1'b0;
    @(negedge clk_in);
  endtask

  // From RUN: set hour/minute fields by key presses, then back to RUN (sec -> 00)
  task automatic set_time(input int hh, input int mm);
    key(1'b1, 1'b0);
    while (t_sod / 3600 != hh) key(1'b0, 1'b1);
    key(1'b1, 1'b0);
    while ((t_sod / 60) % 60 != mm) key(1'b0, 1'b1);
    key(1'b1, 1'b0);
  endtask

  initial begin
    int op;
    rst             = 1'b1;
    bus_if.sec_clk  = 1'b0;
    bus_if.key_mode = 1'b0;
    bus_if.key_inc  = 1'b0;
    days            = 0;
    model_reset();
    repeat (3) @(negedge clk_in);

    // Reset state, and ticks ignored while reset is held
    check_all("rst");
    repeat (3) begin
      bus_if.sec_clk = 1'b1;
      repeat (5) @(negedge clk_in);
      bus_if.sec_clk = 1'b0;
      repeat (5) @(negedge clk_in);
    end
    check_all("rst_held");
    rst = 1'b0;
    repeat (3) @(negedge clk_in);
    check_all("rst_release");

    // 00:00:59 -> one edge -> 00:01:00, then a long-held high level counts once
    set_time(0, 0);
    check_all("preload0");
    repeat (59) sec_tick(1'b0, 1'b0);
    check_all("at_0059");
    sec_tick(1'b0, 1'b0);
    check_all("min_carry");
    bus_if.sec_clk = 1'b1;
    repeat (100) @(negedge clk_in);
    bus_if.sec_clk = 1'b0;
    repeat (3) @(negedge clk_in);
    model_apply(1'b1, 1'b0, 1'b0);
    check_all("held_high");

    // 23:59:59 -> 00:00:00 with a single-cycle day pulse
    set_time(23, 59);
    repeat (59) sec_tick(1'b0, 1'b0);
    check_all("at_235959");
    sec_tick(1'b0, 1'b0);
    check_all("day_roll");

    // Hour edit from 12 wraps to 00; ticks frozen in set mode
    do_reset();
    repeat (7) sec_tick(1'b0, 1'b0);
    check_all("run7");
    key(1'b1, 1'b0);
    repeat (12) key(1'b0, 1'b1);
    check_all("hour_wrap");
    repeat (5) sec_tick(1'b0, 1'b0);
    check_all("frozen");

    // Minute edit 59 -> 00 without hour carry; leaving clears seconds
    key(1'b1, 1'b0);
    repeat (59) key(1'b0, 1'b1);
    check_all("min59");
    key(1'b0, 1'b1);
    check_all("min_wrap");
    key(1'b1, 1'b0);
    check_all("exit_set");

    // Simultaneous events
    sec_tick(1'b0, 1'b0);
    key(1'b1, 1'b1);
    check_all("mode_and_inc");
    key(1'b1, 1'b0);
    key(1'b1, 1'b0);
    sec_tick(1'b1, 1'b0);
    check_all("tick_and_mode");
    sec_tick(1'b0, 1'b1);
    check_all("tick_in_set");

    // Asynchronous reset out of SET_MIN, observed between clock edges
    key(1'b1, 1'b0);
    key(1'b0, 1'b1);
    check_all("in_set_min");
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_all("async_rst");
    @(negedge clk_in);
    rst = 1'b0;
    @(negedge clk_in);

    // Randomized mix of keys and ticks
    for (int i = 0; i < 200; i++) begin
      op = int'($urandom_range(0, 5));
      case (op)
        0: key(1'b1, 1'b0);
        1: key(1'b0, 1'b1);
        2: key(1'b1, 1'b1);
        3: sec_tick(1'b0, 1'b0);
        4: sec_tick(1'b1, 1'b0);
        default: sec_tick(1'b0, 1'b1);
      endcase
      check_all("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
